// File: rtl/upstream_pattern_gen.sv
// Upstream test-traffic source for the GPIF2 bridge rx stream: runtime-selectable
// pattern, packet length, gap and packet count, with a fully registered AXI-Stream output.
module upstream_pattern_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_enable,
    input  logic [1:0]        cfg_mode,
    input  logic [LEN_W-1:0]  cfg_pkt_len,
    input  logic [7:0]        cfg_gap,
    input  logic [CNT_W-1:0]  cfg_pkt_count,
    input  logic [31:0]       cfg_seed,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkts_sent,
    output logic              pkt_toggle
);

    localparam int LANES = DATA_W / 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t            state_reg,   state_next;
    logic [1:0]        mode_reg,    mode_next;
    logic [LEN_W-1:0]  len_reg,     len_next;
    logic [7:0]        gap_reg,     gap_next;
    logic [CNT_W-1:0]  count_reg,   count_next;
    logic [31:0]       seed_reg,    seed_next;
    logic [7:0]        gap_cnt_reg, gap_cnt_next;
    logic [LEN_W-1:0]  idx_reg,     idx_next;
    logic [31:0]       run_reg,     run_next;
    logic [31:0]       lfsr_reg,    lfsr_next;
    logic [CNT_W-1:0]  pkts_reg,    pkts_next;
    logic              toggle_reg,  toggle_next;
    logic [31:0]       word_reg,    word_next;
    logic              tlast_reg,   tlast_next;
    logic              present;
    logic              start_pkt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
    endfunction

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    function automatic logic [31:0] pattern(input logic [1:0]       mode,
                                            input logic [LEN_W-1:0] idx,
                                            input logic [31:0]      run,
                                            input logic [31:0]      lfsr,
                                            input logic [31:0]      seed);
        case (mode)
            2'd0:    return 32'(idx);
            2'd1:    return run;
            2'd2:    return lfsr;
            default: return seed;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            mode_reg    <= '0;
            len_reg     <= '0;
            gap_reg     <= '0;
            count_reg   <= '0;
            seed_reg    <= '0;
            gap_cnt_reg <= '0;
            idx_reg     <= '0;
            run_reg     <= '0;
            lfsr_reg    <= 32'd1;
            pkts_reg    <= '0;
            toggle_reg  <= 1'b0;
            word_reg    <= '0;
            tlast_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            len_reg     <= len_next;
            gap_reg     <= gap_next;
            count_reg   <= count_next;
            seed_reg    <= seed_next;
            gap_cnt_reg <= gap_cnt_next;
            idx_reg     <= idx_next;
            run_reg     <= run_next;
            lfsr_reg    <= lfsr_next;
            pkts_reg    <= pkts_next;
            toggle_reg  <= toggle_next;
            word_reg    <= word_next;
            tlast_reg   <= tlast_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        len_next     = len_reg;
        gap_next     = gap_reg;
        count_next   = count_reg;
        seed_next    = seed_reg;
        gap_cnt_next = gap_cnt_reg;
        idx_next     = idx_reg;
        run_next     = run_reg;
        lfsr_next    = lfsr_reg;
        pkts_next    = pkts_reg;
        toggle_next  = toggle_reg;
        word_next    = word_reg;
        tlast_next   = tlast_reg;
        present      = 1'b0;
        start_pkt    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cfg_enable) begin
                    mode_next  = cfg_mode;
                    len_next   = eff_len(cfg_pkt_len);
                    gap_next   = cfg_gap;
                    count_next = cfg_pkt_count;
                    seed_next  = cfg_seed;
                    pkts_next  = '0;
                    idx_next   = '0;
                    run_next   = '0;
                    lfsr_next  = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
                    present    = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_tready) begin
                    // Counter and LFSR run across packet boundaries; only the index restarts.
                    run_next  = run_reg + 32'd1;
                    lfsr_next = lfsr_step(lfsr_reg);
                    if (tlast_reg) begin
                        pkts_next   = pkts_reg + 1'b1;
                        toggle_next = ~toggle_reg;
                        tlast_next  = 1'b0;
                        if (count_reg != '0 && pkts_next == count_reg) begin
                            state_next = ST_DONE;
                        end else if (!cfg_enable) begin
                            state_next = ST_IDLE;
                        end else if (gap_reg == 8'd0) begin
                            start_pkt = 1'b1;
                        end else begin
                            gap_cnt_next = gap_reg - 8'd1;
                            state_next   = ST_GAP;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                        present  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == 8'd0) begin
                    if (!cfg_enable) begin
                        state_next = ST_IDLE;
                    end else begin
                        start_pkt  = 1'b1;
                        state_next = ST_SEND;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - 8'd1;
                end
            end
            ST_DONE: begin
                if (!cfg_enable) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Mode and length are picked up again at every packet boundary while running.
        if (start_pkt) begin
            mode_next = cfg_mode;
            len_next  = eff_len(cfg_pkt_len);
            idx_next  = '0;
            present   = 1'b1;
        end

        if (present) begin
            word_next  = pattern(mode_next, idx_next, run_next, lfsr_next, seed_next);
            tlast_next = (idx_next == len_next - 1'b1);
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign m_tdata[gi*32 +: 32] = word_reg;
        end
    endgenerate

    assign m_tvalid   = (state_reg == ST_SEND);
    assign m_tlast    = tlast_reg;
    assign busy       = (state_reg == ST_SEND) || (state_reg == ST_GAP);
    assign done       = (state_reg == ST_DONE);
    assign pkts_sent  = pkts_reg;
    assign pkt_toggle = toggle_reg;

endmodule

// File: tb/tb_upstream_pattern_gen.sv
// Directed bench for upstream_pattern_gen: vector table of gap-free runs plus
// hand-written stall/gap, enable-drop, async-reset and 64-bit lane sequences.
module tb_upstream_pattern_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_enable;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_pkt_len;
    logic [7:0]  cfg_gap;
    logic [15:0] cfg_pkt_count;
    logic [31:0] cfg_seed;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready, busy, done, pkt_toggle;
    logic [15:0] pkts_sent;

    logic        w_enable;
    logic [1:0]  w_mode;
    logic [15:0] w_pkt_len;
    logic [7:0]  w_gap;
    logic [15:0] w_pkt_count;
    logic [31:0] w_seed;
    logic [63:0] w_tdata;
    logic        w_tvalid, w_tlast, w_tready, w_busy, w_done, w_toggle;
    logic [15:0] w_pkts_sent;

    upstream_pattern_gen #(.DATA_W(32), .LEN_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap), .cfg_pkt_count(cfg_pkt_count),
        .cfg_seed(cfg_seed), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .busy(busy), .done(done), .pkts_sent(pkts_sent),
        .pkt_toggle(pkt_toggle)
    );

    upstream_pattern_gen #(.DATA_W(64), .LEN_W(16), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .cfg_enable(w_enable), .cfg_mode(w_mode),
        .cfg_pkt_len(w_pkt_len), .cfg_gap(w_gap), .cfg_pkt_count(w_pkt_count),
        .cfg_seed(w_seed), .m_tdata(w_tdata), .m_tvalid(w_tvalid), .m_tlast(w_tlast),
        .m_tready(w_tready), .busy(w_busy), .done(w_done), .pkts_sent(w_pkts_sent),
        .pkt_toggle(w_toggle)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_toggle = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]        mode;
        logic [15:0]       len;
        logic [15:0]       count;
        logic [31:0]       seed;
        logic [3:0]        nbeats;
        logic [7:0][31:0]  data;
        logic [7:0]        last;
    } vec_t;

    vec_t vecs[6];

    initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        vecs[0] = '{mode: 2'd0, len: 16'd4, count: 16'd2, seed: 32'd0, nbeats: 4'd8,
                    data: {32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0}, last: 8'b1000_1000};
        vecs[1] = '{mode: 2'd2, len: 16'd4, count: 16'd1, seed: 32'd1, nbeats: 4'd4,
                    data: {32'd0, 32'd0, 32'd0, 32'd0, 32'hD, 32'h6, 32'h3, 32'h1}, last: 8'b0000_1000};
        vecs[2] = '{mode: 2'd2, len: 16'd4, count: 16'd1, seed: 32'd0, nbeats: 4'd4,
                    data: {32'd0, 32'd0, 32'd0, 32'd0, 32'hD, 32'h6, 32'h3, 32'h1}, last: 8'b0000_1000};
        vecs[3] = '{mode: 2'd3, len: 16'd2, count: 16'd2, seed: 32'hDEADBEEF, nbeats: 4'd4,
                    data: {32'd0, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF},
                    last: 8'b0000_1010};
        vecs[4] = '{mode: 2'd1, len: 16'd3, count: 16'd2, seed: 32'd0, nbeats: 4'd6,
                    data: {32'd0, 32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0}, last: 8'b0010_0100};
        vecs[5] = '{mode: 2'd0, len: 16'd0, count: 16'd3, seed: 32'd0, nbeats: 4'd3,
                    data: {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, last: 8'b0000_0111};

        rst_n = 1'b0; cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_pkt_len = 16'd0; cfg_gap = 8'd0;
        cfg_pkt_count = 16'd0; cfg_seed = 32'd0; m_tready = 1'b0;
        w_enable = 1'b0; w_mode = 2'd0; w_pkt_len = 16'd0; w_gap = 8'd0; w_pkt_count = 16'd0;
        w_seed = 32'd0; w_tready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.tvalid", m_tvalid, 0);
        chk("rst.tlast", m_tlast, 0);
        chk("rst.tdata", m_tdata, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pkts", pkts_sent, 0);
        chk("rst.toggle", pkt_toggle, 0);
        chk("rst.w_tdata", w_tdata, 0);
        rst_n = 1'b1;

        // Gap-free runs with m_tready held high: every beat lands on a consecutive cycle.
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            cfg_mode = vecs[r].mode; cfg_pkt_len = vecs[r].len; cfg_gap = 8'd0;
            cfg_pkt_count = vecs[r].count; cfg_seed = vecs[r].seed; m_tready = 1'b1; cfg_enable = 1'b1;
            for (int b = 0; b < int'(vecs[r].nbeats); b++) begin
                @(negedge clk);
                chk($sformatf("v%0d.valid[%0d]", r, b), m_tvalid, 1);
                chk($sformatf("v%0d.data[%0d]", r, b), m_tdata, vecs[r].data[b]);
                chk($sformatf("v%0d.last[%0d]", r, b), m_tlast, vecs[r].last[b]);
            end
            if (vecs[r].count[0]) exp_toggle = ~exp_toggle;
            @(negedge clk);
            chk($sformatf("v%0d.end_valid", r), m_tvalid, 0);
            chk($sformatf("v%0d.done", r), done, 1);
            chk($sformatf("v%0d.pkts", r), pkts_sent, vecs[r].count);
            chk($sformatf("v%0d.toggle", r), pkt_toggle, exp_toggle);
            cfg_enable = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d.done_clr", r), done, 0);
        end

        // Running counter with gap 3 under random backpressure.
        begin
            int   exp_idx = 0, cyc = 0, gap_n = 0;
            logic counting = 1'b0, stalled = 1'b0, rdy;
            logic [31:0] prev_data = '0;
            logic prev_last = 1'b0;
            cfg_mode = 2'd1; cfg_pkt_len = 16'd3; cfg_gap = 8'd3; cfg_pkt_count = 16'd2;
            m_tready = 1'b0; cfg_enable = 1'b1;
            while (exp_idx < 6 && cyc < 300) begin
                @(negedge clk);
                cyc++;
                if (stalled)
                    chk("bp.hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_last, prev_data});
                if (counting && m_tvalid) begin
                    chk("bp.gap_len", gap_n, 3);
                    counting = 1'b0;
                end else if (counting) begin
                    gap_n++;
                end
                rdy = 1'($urandom_range(0, 1));
                m_tready = rdy;
                stalled = m_tvalid && !rdy;
                prev_data = m_tdata; prev_last = m_tlast;
                if (m_tvalid && rdy) begin
                    chk($sformatf("bp.data[%0d]", exp_idx), m_tdata, exp_idx);
                    chk($sformatf("bp.last[%0d]", exp_idx), m_tlast, (exp_idx % 3) == 2);
                    if (m_tlast) begin counting = 1'b1; gap_n = 0; end
                    exp_idx++;
                end
            end
            chk("bp.beats", exp_idx, 6);
            @(negedge clk);
            chk("bp.done", done, 1);
            chk("bp.pkts", pkts_sent, 2);
            m_tready = 1'b1; cfg_enable = 1'b0;
            @(negedge clk);
        end

        // Unlimited count, enable dropped during packet 2: packet 2 completes, then idle.
        begin
            int   beats = 0;
            logic last_seen = 1'b0;
            cfg_mode = 2'd0; cfg_pkt_len = 16'd8; cfg_gap = 8'd0; cfg_pkt_count = 16'd0;
            m_tready = 1'b1; cfg_enable = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (m_tvalid) begin
                    chk($sformatf("drop.data[%0d]", beats), m_tdata, beats % 8);
                    beats++;
                    last_seen = m_tlast;
                    if (beats == 11) cfg_enable = 1'b0;
                end
            end
            chk("drop.beats", beats, 16);
            chk("drop.final_last", last_seen, 1);
            chk("drop.done", done, 0);
            chk("drop.pkts", pkts_sent, 2);
            chk("drop.busy", busy, 0);
        end

        // Asynchronous reset while a tlast beat is being presented.
        begin
            int   cyc = 0;
            logic found = 1'b0;
            cfg_mode = 2'd0; cfg_pkt_len = 16'd2; cfg_gap = 8'd0; cfg_pkt_count = 16'd0;
            cfg_enable = 1'b1;
            while (!found && cyc < 50) begin
                @(negedge clk);
                cyc++;
                found = m_tvalid && m_tlast && (pkts_sent != 16'd0);
            end
            chk("arst.reached", found, 1);
            #2 rst_n = 1'b0;
            #1;
            chk("arst.tvalid", m_tvalid, 0);
            chk("arst.tlast", m_tlast, 0);
            chk("arst.busy", busy, 0);
            chk("arst.pkts", pkts_sent, 0);
            chk("arst.toggle", pkt_toggle, 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("arst.restart_valid", m_tvalid, 1);
            chk("arst.restart_data0", m_tdata, 0);
            chk("arst.restart_last0", m_tlast, 0);
            @(negedge clk);
            chk("arst.restart_data1", m_tdata, 1);
            chk("arst.restart_last1", m_tlast, 1);
            cfg_enable = 1'b0;
            @(negedge clk);
            chk("arst.idle_busy", busy, 0);
            chk("arst.idle_pkts", pkts_sent, 1);
            chk("arst.idle_toggle", pkt_toggle, 1);
        end

        // 64-bit instance, constant mode, zero length means one-word packets.
        @(negedge clk);
        w_mode = 2'd3; w_seed = 32'hA5A5_0001; w_pkt_len = 16'd0; w_gap = 8'd0;
        w_pkt_count = 16'd3; w_tready = 1'b1; w_enable = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk($sformatf("w64.valid[%0d]", b), w_tvalid, 1);
            chk($sformatf("w64.data[%0d]", b), w_tdata, 64'hA5A50001A5A50001);
            chk($sformatf("w64.last[%0d]", b), w_tlast, 1);
        end
        @(negedge clk);
        chk("w64.done", w_done, 1);
        chk("w64.pkts", w_pkts_sent, 3);
        w_enable = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
